// File: rtl/hazard_forward_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit_pkg
// Shared constants and types for the pipeline hazard/forwarding control block.
//   - FWD_SEL_*  : encodings of the 3:1 operand-mux select lines
//   - state_t    : hazard FSM state encoding
//   - REG_ZERO   : index of the hard-wired zero register (never forwarded)
//   - WAIT_CNT_W : width of the data-memory wait counter
// -----------------------------------------------------------------------------
package hazard_forward_unit_pkg;

    localparam logic [1:0] FWD_SEL_REGFILE = 2'b00;
    localparam logic [1:0] FWD_SEL_WB      = 2'b01;
    localparam logic [1:0] FWD_SEL_MEM     = 2'b10;

    localparam int REG_ZERO   = 0;
    localparam int WAIT_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LD_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_forward_unit_forward_select.sv
// -----------------------------------------------------------------------------
// forward_select
// Purely combinational select generator for one ALU operand mux.
// Ports:
//   rs               in  source register read by the instruction in EX
//   ex_mem_rd        in  destination register of the instruction in MEM
//   ex_mem_reg_write in  MEM instruction writes the register file
//   mem_wb_rd        in  destination register of the instruction in WB
//   mem_wb_reg_write in  WB instruction writes the register file
//   sel              out 00 regfile, 01 WB result, 10 EX/MEM result
// -----------------------------------------------------------------------------
module forward_select
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic                  ex_mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  logic                  mem_wb_reg_write,
    output logic [1:0]            sel
);

    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = ex_mem_reg_write && (ex_mem_rd != ZERO) && (ex_mem_rd == rs);
    assign hit_wb  = mem_wb_reg_write && (mem_wb_rd != ZERO) && (mem_wb_rd == rs);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        sel = FWD_SEL_REGFILE;
        if (hit_mem) begin
            sel = FWD_SEL_MEM;
        end else if (hit_wb) begin
            sel = FWD_SEL_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
// Operand forwarding selects plus stall/bubble/flush control for a 5-stage
// RISC-V pipeline. Forwarding is combinational; load-use bubbles and
// data-memory wait states are sequenced by a 3-state FSM with a saturating
// wait counter that raises a one-cycle mem_timeout pulse.
//
// Ports:
//   clk, reset                      core clock, async active-high reset
//   if_id_rs1/rs2                   sources of the instruction in ID
//   id_ex_rs1/rs2, id_ex_rd         sources/dest of the instruction in EX
//   id_ex_mem_read                  EX instruction is a load
//   ex_branch_taken                 EX resolved a taken branch/jump
//   ex_mem_rd, mem_wb_rd            dests in MEM / WB
//   ex_mem_reg_write, mem_wb_reg_write  write enables in MEM / WB
//   ex_mem_mem_req, mem_ready       data-memory request / completion
//   fwd_a_sel, fwd_b_sel            operand mux selects
//   stall_pc/if_id/id_ex/ex_mem     hold the corresponding register
//   bubble_ex, bubble_wb            insert NOP into ID/EX or MEM/WB
//   flush_if_id                     squash IF/ID
//   mem_timeout                     wait counter reached MEM_TIMEOUT
//   state                           current FSM state (debug)
//   stall_cycles, flush_count, load_use_count
//                                   perf counters, only with HAZARD_PERF_CNT_EN
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//
// Memory handshake: ex_mem_mem_req is the valid side and is held by the MEM
// stage until the access completes; mem_ready completes the access in the
// cycle it is seen together with ex_mem_mem_req. A request that drops while
// waiting is treated as completed.
// -----------------------------------------------------------------------------
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic [REG_ADDR_W-1:0] id_ex_rs1,
    input  logic [REG_ADDR_W-1:0] id_ex_rs2,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  logic                  ex_mem_reg_write,
    input  logic                  mem_wb_reg_write,
    input  logic                  ex_mem_mem_req,
    input  logic                  mem_ready,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  stall_ex_mem,
    output logic                  bubble_ex,
    output logic                  bubble_wb,
    output logic                  flush_if_id,
    output logic                  mem_timeout,
    output state_t                state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic [CNT_W-1:0]      load_use_count
`endif
);

    localparam logic [REG_ADDR_W-1:0] ZERO       = REG_ADDR_W'(REG_ZERO);
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs               (id_ex_rs1),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .sel              (sel_a)
    );

    forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs               (id_ex_rs2),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .sel              (sel_b)
    );

    // ------------------------------------------------------------------
    // Hazard FSM
    // ------------------------------------------------------------------
    state_t                state_q;
    state_t                state_d;
    logic [WAIT_CNT_W-1:0] wait_q;
    logic [WAIT_CNT_W-1:0] wait_d;

    logic load_use;
    logic mem_stall;
    logic stall_all_c;   // all four stalls plus bubble_wb
    logic stall_front_c; // stall_pc/stall_if_id only (load-use)
    logic bubble_ex_c;
    logic flush_c;
    logic timeout_c;

    assign load_use  = id_ex_mem_read && (id_ex_rd != ZERO) &&
                       ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    assign mem_stall = ex_mem_mem_req && !mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        stall_all_c   = 1'b0;
        stall_front_c = 1'b0;
        bubble_ex_c   = 1'b0;
        flush_c       = 1'b0;
        case (state_q)
            RUN, LD_BUBBLE: begin
                if (mem_stall) begin
                    stall_all_c = 1'b1;
                    state_d     = MEM_WAIT;
                    wait_d      = WAIT_CNT_W'(1);
                end else if (ex_branch_taken) begin
                    // ID instruction is squashed, so its load-use is moot.
                    flush_c     = 1'b1;
                    bubble_ex_c = 1'b1;
                    state_d     = RUN;
                end else if ((state_q == RUN) && load_use) begin
                    stall_front_c = 1'b1;
                    bubble_ex_c   = 1'b1;
                    state_d       = LD_BUBBLE;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    // EX is frozen, so a taken branch there waits for RUN.
                    stall_all_c = 1'b1;
                    if (wait_q != TIMEOUT_VAL) begin
                        wait_d = wait_q + WAIT_CNT_W'(1);
                    end
                end else begin
                    wait_d  = '0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
        // Pulse only on the first cycle the count lands on the limit.
        timeout_c = stall_all_c && (wait_d == TIMEOUT_VAL) && (wait_q != TIMEOUT_VAL);
    end

    // Outputs are forced low while reset is held, independent of inputs.
    assign fwd_a_sel    = reset ? FWD_SEL_REGFILE : sel_a;
    assign fwd_b_sel    = reset ? FWD_SEL_REGFILE : sel_b;
    assign stall_pc     = !reset && (stall_all_c || stall_front_c);
    assign stall_if_id  = !reset && (stall_all_c || stall_front_c);
    assign stall_id_ex  = !reset && stall_all_c;
    assign stall_ex_mem = !reset && stall_all_c;
    assign bubble_wb    = !reset && stall_all_c;
    assign bubble_ex    = !reset && bubble_ex_c;
    assign flush_if_id  = !reset && flush_c;
    assign mem_timeout  = !reset && timeout_c;
    assign state        = state_q;

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles   <= '0;
            flush_count    <= '0;
            load_use_count <= '0;
        end else begin
            if (stall_pc && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_if_id && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
            if ((state_q == RUN) && (state_d == LD_BUBBLE) && (load_use_count != CNT_MAX)) begin
                load_use_count <= load_use_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
// Directed bench for hazard_forward_unit built with MEM_TIMEOUT=4.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit
// after that, well before the next rising edge.
// Control vector layout used in checks:
//   {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
//    bubble_ex, bubble_wb, flush_if_id, mem_timeout}
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;
    import hazard_forward_unit_pkg::*;

    localparam int RW = 5;

    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_MEM   = 8'b1111_0100;
    localparam logic [7:0] C_MEMTO = 8'b1111_0101;
    localparam logic [7:0] C_LU    = 8'b1100_1000;
    localparam logic [7:0] C_BR    = 8'b0000_1010;

    logic          clk;
    logic          reset;
    logic [RW-1:0] if_id_rs1, if_id_rs2;
    logic [RW-1:0] id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic          id_ex_mem_read, ex_branch_taken;
    logic [RW-1:0] ex_mem_rd, mem_wb_rd;
    logic          ex_mem_reg_write, mem_wb_reg_write;
    logic          ex_mem_mem_req, mem_ready;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic          bubble_ex, bubble_wb, flush_if_id, mem_timeout;
    state_t        state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stall_cycles, flush_count, load_use_count;
`endif

    int total = 0;
    int bad   = 0;

    hazard_forward_unit #(
        .REG_ADDR_W  (RW),
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .if_id_rs1        (if_id_rs1),
        .if_id_rs2        (if_id_rs2),
        .id_ex_rs1        (id_ex_rs1),
        .id_ex_rs2        (id_ex_rs2),
        .id_ex_rd         (id_ex_rd),
        .id_ex_mem_read   (id_ex_mem_read),
        .ex_branch_taken  (ex_branch_taken),
        .ex_mem_rd        (ex_mem_rd),
        .mem_wb_rd        (mem_wb_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_reg_write (mem_wb_reg_write),
        .ex_mem_mem_req   (ex_mem_mem_req),
        .mem_ready        (mem_ready),
        .fwd_a_sel        (fwd_a_sel),
        .fwd_b_sel        (fwd_b_sel),
        .stall_pc         (stall_pc),
        .stall_if_id      (stall_if_id),
        .stall_id_ex      (stall_id_ex),
        .stall_ex_mem     (stall_ex_mem),
        .bubble_ex        (bubble_ex),
        .bubble_wb        (bubble_wb),
        .flush_if_id      (flush_if_id),
        .mem_timeout      (mem_timeout),
        .state            (state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count),
        .load_use_count   (load_use_count)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [7:0] ctl();
        return {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                bubble_ex, bubble_wb, flush_if_id, mem_timeout};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        if_id_rs1 = '0; if_id_rs2 = '0;
        id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0;
        id_ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        ex_mem_rd = '0; mem_wb_rd = '0;
        ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0;
        ex_mem_mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held with hazard-provoking inputs: everything must read 0.
        set_idle();
        reset = 1'b1;
        id_ex_rs1 = 5'd5; ex_mem_rd = 5'd5; ex_mem_reg_write = 1'b1;
        ex_mem_mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        check("rst_ctl",   32'(ctl()),     32'(C_NONE));
        check("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        check("rst_state", 32'(state),     32'(RUN));
        set_idle();
        tick();
        reset = 1'b0;
        #1;
        check("idle_ctl", 32'(ctl()), 32'(C_NONE));

        // Forwarding: MEM over WB, then WB, then x0 never forwarded.
        id_ex_rs1 = 5'd5; id_ex_rs2 = 5'd3;
        ex_mem_rd = 5'd5; ex_mem_reg_write = 1'b1;
        mem_wb_rd = 5'd5; mem_wb_reg_write = 1'b1;
        #1;
        check("fwd_a_mem", 32'(fwd_a_sel), 32'b10);
        check("fwd_b_none", 32'(fwd_b_sel), 32'b00);
        ex_mem_reg_write = 1'b0;
        #1;
        check("fwd_a_wb", 32'(fwd_a_sel), 32'b01);
        ex_mem_reg_write = 1'b1;
        id_ex_rs1 = 5'd0; ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
        #1;
        check("fwd_a_x0", 32'(fwd_a_sel), 32'b00);
        id_ex_rs1 = 5'd4; id_ex_rs2 = 5'd9; ex_mem_rd = 5'd4; mem_wb_rd = 5'd9;
        #1;
        check("fwd_a_mem2", 32'(fwd_a_sel), 32'b10);
        check("fwd_b_wb",   32'(fwd_b_sel), 32'b01);
        check("fwd_ctl0",   32'(ctl()),     32'(C_NONE));

        // Load-use on rs2: one bubble cycle, then suppressed, then RUN.
        tick();
        set_idle();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; if_id_rs2 = 5'd7;
        #1;
        check("lu_ctl", 32'(ctl()), 32'(C_LU));
        tick();
        check("lu_state", 32'(state), 32'(LD_BUBBLE));
        check("lu_suppr", 32'(ctl()), 32'(C_NONE));
        set_idle();
        tick();
        check("lu_back_run", 32'(state), 32'(RUN));
        check("lu_after",    32'(ctl()), 32'(C_NONE));

        // Load-use together with taken branch: flush wins, no LD_BUBBLE.
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; if_id_rs1 = 5'd7;
        ex_branch_taken = 1'b1;
        #1;
        check("br_lu_ctl", 32'(ctl()), 32'(C_BR));
        set_idle();
        tick();
        check("br_lu_state", 32'(state), 32'(RUN));

        // Memory wait of 3 cycles with a taken branch pending in EX.
        ex_mem_mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check($sformatf("mw3_ctl_%0d", k), 32'(ctl()), 32'(C_MEM));
            tick();
        end
        check("mw3_state", 32'(state), 32'(MEM_WAIT));
        mem_ready = 1'b1;
        #1;
        check("mw3_done_ctl", 32'(ctl()), 32'(C_NONE));
        tick();
        check("mw3_run", 32'(state), 32'(RUN));
        ex_mem_mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        check("mw3_br_serviced", 32'(ctl()), 32'(C_BR));
        set_idle();
        tick();

        // Timeout: ready low for 10 cycles, pulse only on wait cycle 4.
        ex_mem_mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            check($sformatf("to_ctl_%0d", k), 32'(ctl()), (k == 4) ? 32'(C_MEMTO) : 32'(C_MEM));
            tick();
        end
        // Asynchronous reset mid-wait, away from any clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("arst_ctl",   32'(ctl()), 32'(C_NONE));
        check("arst_state", 32'(state), 32'(RUN));
        set_idle();
        tick();
        reset = 1'b0;
        #1;
        check("arst_after", 32'(ctl()), 32'(C_NONE));
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall0", stall_cycles,   32'd0);
        check("perf_flush0", flush_count,    32'd0);
        check("perf_lu0",    load_use_count, 32'd0);
`endif

        // Request drop while waiting counts as completion.
        ex_mem_mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        check("drop_state", 32'(state), 32'(MEM_WAIT));
        ex_mem_mem_req = 1'b0;
        #1;
        check("drop_ctl", 32'(ctl()), 32'(C_NONE));
        tick();
        check("drop_run", 32'(state), 32'(RUN));

        // Ready in the same cycle as the request: no stall.
        ex_mem_mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        check("same_ready_ctl", 32'(ctl()), 32'(C_NONE));
        tick();
        check("same_ready_run", 32'(state), 32'(RUN));

        // Memory stall arriving while in LD_BUBBLE still takes priority.
        set_idle();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd3; if_id_rs1 = 5'd3;
        tick();
        check("lb_state", 32'(state), 32'(LD_BUBBLE));
        ex_mem_mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        check("lb_mem_ctl", 32'(ctl()), 32'(C_MEM));
        tick();
        check("lb_mem_state", 32'(state), 32'(MEM_WAIT));
        set_idle();
        tick();
        check("lb_final_run", 32'(state), 32'(RUN));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
